fir_interp: RTL and testbench
=============================

# fir_interp

Dual-channel polyphase interpolating FIR (upsample by 8). It runs in the opposite direction from the team's decimating FIR. It accepts one packed two-channel sample word and emits one 256-bit word carrying 8 parallel output samples per channel. The output lane packing is identical to the decimator's input word, so the two blocks can be chained in loopback. It sits on the transmit/stimulus path and shares the same 121-tap coefficient file.

## Interface
- TAP_COUNT, 121: prototype filter taps.
- DATA_WIDTH, 16: sample width, signed.
- COEF_WIDTH, 16: coefficient width, signed.
- INTERP, 8: interpolation factor, equal to the number of output lanes per channel.
- ACC_WIDTH, 48: accumulator width.
- OUT_SHIFT, 12: arithmetic right shift applied to the accumulator before output.

- clk  in  1  single clock; all flops on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  block can accept a sample.
- s_tdata  in  2*DATA_WIDTH  packed input sample.
  - [15:0] is ch0, [31:16] is ch1.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream accepts the output word.
- m_tdata  out  2*INTERP*DATA_WIDTH  output word.
  - ch0 lane p occupies [p*16 +: 16].
  - ch1 lane p occupies [128 + p*16 +: 16].

## Operation
- Coefficients are loaded with $readmemh("fir_coe.txt") into 128 entries; entries 121..127 are zero.
- Polyphase decomposition: PHASE_TAPS = 16.
  - Coefficient for phase p, tap t is coef[t*8 + p].
- Each channel has a 16-deep history register; hist[0] holds the newest sample.
- FSM states:
  - IDLE: s_tready=1. On s_tvalid&&s_tready, shift the history (hist[t] <= hist[t-1], hist[0] <= new sample), clear the accumulators, set p=0, t=0, and go to CALC.
  - CALC: s_tready=0. Each cycle, acc += hist[t]*coef[t*8+p] for each channel. There is one multiplier per channel, and the product is a full 32-bit signed value.
    - At t=15, the final sum is rounded and saturated and written to lane p of the output register. The accumulator is then cleared, t wraps to 0 and p increments.
    - At p=7, t=15, the FSM goes to OUT.
  - OUT: m_tvalid=1 and m_tdata is held stable. On m_tready, go to IDLE.
- Rounding and saturation:
  - Compute y = (acc + (1<<(OUT_SHIFT-1))) >>> OUT_SHIFT.
  - Clamp y to [-32768, 32767].
- s_tdata presented while s_tready=0 is ignored and not captured.

## Timing
- Reset values: s_tready=0, m_tvalid=0, m_tdata=0, history=0, accumulators=0, state=IDLE.
  - s_tready rises on the first clk edge after nrst deasserts, via a registered reset-done flag.
- Latency: if the input handshake occurs at edge E0, then:
  - edges E1..E128 each perform one MAC;
  - m_tvalid is high after E128.
- Throughput: at most one input every 130 cycles when m_tready is held high.
- m_tvalid and m_tdata must not change until m_tready is sampled high.
- s_tready rises on the edge that completes the output handshake; the block never accepts input while OUT is stalled.
- All control outputs are registered; there is no combinational path from s_tvalid or m_tready to any output.
- nrst asserted in any state, including mid-CALC or a stalled OUT:
  - all state clears immediately and the partial result is discarded;
  - m_tvalid falls asynchronously.

## Structure
- Package fir_pkg holds:
  - TAP_COUNT, INTERP, PHASE_TAPS, DATA_WIDTH, COEF_WIDTH, ACC_WIDTH;
  - an FSM state enum {IDLE, CALC, OUT};
  - a round_sat function;
  - the lane pack/unpack index functions shared with the decimator.
- Sub-module fir_interp_mac is instantiated once per channel. It contains the accumulator, the multiplier and the round/saturate stage, and takes clr/en/last controls from the top-level FSM.

## Test plan
- Impulse: ch0=0x1000 then 15 zero samples, ch1=0.
  - Output word n, lane p of ch0 must equal round_sat(0x1000*coef[8n+p]).
  - All ch1 lanes must be 0.
- DC test: alternate coefficient file with all 121 entries 0x0800; hold ch0=ch1=0x0100 for 16+ samples.
  - Steady state: lane 0 = 0x0800 and lanes 1..7 = 0x0780 on both channels (phase 0 has 16 taps, the others 15).
- Saturation test: coefficient file all 0x7FFF; hold ch0=0x8000 and ch1=0x7FFF.
  - Steady state: all ch0 lanes = 0x8000 and all ch1 lanes = 0x7FFF.
- Backpressure test: hold m_tready low for 20 cycles after m_tvalid rises while s_tvalid is high with changing data.
  - m_tdata must be stable and s_tready must be 0 throughout.
  - The next accepted sample must be the one present when s_tready returns high.
- Latency test: single handshake with m_tready=1.
  - m_tvalid must be high exactly 128 edges after the accepting edge, for one cycle.
  - s_tready must be high on the following cycle.
- Reset mid-CALC test: assert nrst 60 cycles into CALC.
  - m_tvalid and s_tready must drop immediately.
  - After release, a fresh impulse must yield the exact impulse response with no residue from the earlier sample.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state, rounding and lane packing for the FIR blocks.
package fir_pkg;
    localparam int TAP_COUNT = 121;
    localparam int INTERP = 8;
    localparam int PHASE_TAPS = 16;
    localparam int CHANNELS = 2;
    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int ACC_WIDTH = 48;
    localparam int OUT_SHIFT = 12;
    localparam int COEF_DEPTH = INTERP * PHASE_TAPS;
    localparam int P_W = $clog2(INTERP);
    localparam int T_W = $clog2(PHASE_TAPS);
    localparam logic signed [ACC_WIDTH-1:0] ROUND = ACC_WIDTH'(1 << (OUT_SHIFT - 1));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    function automatic logic signed [DATA_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] y;
        y = (acc + ROUND) >>> OUT_SHIFT;
        return y > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0] : y < SAT_MIN ? SAT_MIN[DATA_WIDTH-1:0] : y[DATA_WIDTH-1:0];
    endfunction

    function automatic int sample_lsb(input int ch);
        return ch * DATA_WIDTH;
    endfunction

    function automatic int lane_lsb(input int ch, input int p);
        return (ch * INTERP + p) * DATA_WIDTH;
    endfunction

    // Built-in prototype filter; entries past TAP_COUNT stay zero.
    function automatic logic [COEF_DEPTH*COEF_WIDTH-1:0] default_coefs();
        logic [COEF_DEPTH*COEF_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < TAP_COUNT; i++)
            c[i*COEF_WIDTH +: COEF_WIDTH] = COEF_WIDTH'((i * 97 % 251) * 61 - 7000);
        return c;
    endfunction
endpackage

// File: rtl/fir_interp_mac.sv
// fir_interp_mac: per-channel multiply-accumulate with round/saturate of the phase sum.
module fir_interp_mac
    import fir_pkg::*;
(
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic                         last_i,
    input  logic signed [DATA_WIDTH-1:0] sample_i,
    input  logic signed [COEF_WIDTH-1:0] coef_i,
    output logic signed [DATA_WIDTH-1:0] y_o
);
    logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum;

    always_comb begin
        prod = sample_i * coef_i;
        sum = acc_q + ACC_WIDTH'(prod);
        acc_d = (clr_i || (en_i && last_i)) ? '0 : en_i ? sum : acc_q;
        y_o = round_sat(sum);
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) acc_q <= '0;
        else acc_q <= acc_d;
endmodule

// File: rtl/fir_interp.sv
// fir_interp: dual-channel 8x polyphase interpolating FIR, one MAC per channel,
// 128 MAC cycles per input sample producing 8 lanes per channel.
module fir_interp
    import fir_pkg::*;
#(
    parameter logic [COEF_DEPTH*COEF_WIDTH-1:0] COEFS = default_coefs()
) (
    input  logic                                  clk,
    input  logic                                  nrst,
    input  logic                                  s_tvalid,
    output logic                                  s_tready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        s_tdata,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [CHANNELS*INTERP*DATA_WIDTH-1:0] m_tdata
);
    state_t state_q;
    logic [P_W-1:0] p_q;
    logic [T_W-1:0] t_q;
    logic s_tready_q, m_tvalid_q;
    logic [CHANNELS*INTERP*DATA_WIDTH-1:0] m_tdata_q;
    logic [CHANNELS-1:0][PHASE_TAPS-1:0][DATA_WIDTH-1:0] hist_q;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0] y;
    logic [T_W+P_W-1:0] cidx;
    logic signed [COEF_WIDTH-1:0] coef;
    logic accept, en, last;

    always_comb begin
        cidx = {t_q, p_q};
        coef = int'(cidx) < TAP_COUNT ? $signed(COEFS[int'(cidx)*COEF_WIDTH +: COEF_WIDTH]) : '0;
        accept = s_tvalid && s_tready_q;
        en = state_q == CALC;
        last = t_q == T_W'(PHASE_TAPS - 1);
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        fir_interp_mac u_mac (
            .clk      (clk),
            .nrst     (nrst),
            .clr_i    (accept),
            .en_i     (en),
            .last_i   (last),
            .sample_i (hist_q[c][t_q]),
            .coef_i   (coef),
            .y_o      (y[c])
        );
    end

    // s_tready_q doubles as the reset-done flag: it first rises on the edge after reset release.
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state_q <= IDLE;
            p_q <= '0;
            t_q <= '0;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q <= '0;
            hist_q <= '0;
        end else begin
            unique case (state_q)
                IDLE:
                    if (accept) begin
                        for (int c = 0; c < CHANNELS; c++)
                            hist_q[c] <= {hist_q[c][PHASE_TAPS-2:0], s_tdata[sample_lsb(c) +: DATA_WIDTH]};
                        p_q <= '0;
                        t_q <= '0;
                        s_tready_q <= 1'b0;
                        state_q <= CALC;
                    end else begin
                        s_tready_q <= 1'b1;
                    end
                CALC: begin
                    t_q <= t_q + T_W'(1);
                    if (last) begin
                        for (int c = 0; c < CHANNELS; c++)
                            m_tdata_q[lane_lsb(c, int'(p_q)) +: DATA_WIDTH] <= y[c];
                        p_q <= p_q + P_W'(1);
                        if (p_q == P_W'(INTERP - 1)) begin
                            state_q <= OUT;
                            m_tvalid_q <= 1'b1;
                        end
                    end
                end
                OUT:
                    if (m_tready) begin
                        state_q <= IDLE;
                        m_tvalid_q <= 1'b0;
                        s_tready_q <= 1'b1;
                    end
                default: state_q <= IDLE;
            endcase
        end

    assign s_tready = s_tready_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tdata = m_tdata_q;
endmodule

// File: tb/tb_fir_interp.sv
// tb_fir_interp: scoreboard bench for fir_interp plus free-running DC and saturation instances.
module tb_fir_interp;
    logic clk = 1'b0;
    logic nrst, s_tvalid, m_tready, s_tready, m_tvalid;
    logic [31:0] s_tdata;
    logic [255:0] m_tdata;
    logic dc_s_tready, dc_m_tvalid, sat_s_tready, sat_m_tvalid;
    logic [255:0] dc_m_tdata, sat_m_tdata;
    int passed = 0;
    int total = 0;
    int h[2][16];
    logic [255:0] exp_q[$];
    localparam logic [127:0] DC_CH = {{7{16'h0780}}, 16'h0800};
    localparam logic [255:0] SAT_W = {{8{16'h7fff}}, {8{16'h8000}}};

    fir_interp dut (
        .clk(clk), .nrst(nrst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata)
    );

    fir_interp #(.COEFS({128{16'h0800}})) dut_dc (
        .clk(clk), .nrst(nrst), .s_tvalid(1'b1), .s_tready(dc_s_tready), .s_tdata(32'h0100_0100),
        .m_tvalid(dc_m_tvalid), .m_tready(1'b1), .m_tdata(dc_m_tdata)
    );

    fir_interp #(.COEFS({128{16'h7fff}})) dut_sat (
        .clk(clk), .nrst(nrst), .s_tvalid(1'b1), .s_tready(sat_s_tready), .s_tdata(32'h7fff_8000),
        .m_tvalid(sat_m_tvalid), .m_tready(1'b1), .m_tdata(sat_m_tdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int coef_m(input int i);
        return i < 121 ? (i * 97 % 251) * 61 - 7000 : 0;
    endfunction

    function automatic logic [255:0] model_word();
        logic [255:0] w;
        longint acc, v;
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 8; p++) begin
                acc = 0;
                for (int t = 0; t < 16; t++) acc += longint'(h[c][t]) * longint'(coef_m(t * 8 + p));
                v = (acc + 2048) >>> 12;
                v = v > 32767 ? 32767 : v < -32768 ? -32768 : v;
                w[c*128 + p*16 +: 16] = v[15:0];
            end
        return w;
    endfunction

    task automatic model_accept(input logic [31:0] d);
        for (int c = 0; c < 2; c++) begin
            for (int t = 15; t > 0; t--) h[c][t] = h[c][t-1];
            h[c][0] = c == 1 ? int'($signed(d[31:16])) : int'($signed(d[15:0]));
        end
        exp_q.push_back(model_word());
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 16; t++) h[c][t] = 0;
        exp_q.delete();
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] d);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata = d;
        @(negedge clk);
        while (!s_tready && n < 400) begin @(negedge clk); n++; end
        check("accept", 256'(n < 400), 256'(1));
        model_accept(d);
        @(posedge clk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!m_tvalid && n < 300) begin @(negedge clk); n++; end
        check(tag, 256'(m_tvalid), 256'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
        check("drain", 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [255:0] e;
        if (nrst && m_tvalid && m_tready) begin
            e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
            check("word", m_tdata, e);
        end
    end

    initial begin
        int n;
        logic [255:0] snap;
        nrst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 256'(s_tready), 256'(0));
        check("rst_m_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_m_tdata", m_tdata, 256'(0));
        @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 256'(s_tready), 256'(0));
        @(negedge clk);
        check("ready_after_release", 256'(s_tready), 256'(1));

        // latency on the first impulse sample, then the rest of the impulse
        m_tready = 1'b1;
        @(posedge clk);
        #1 send(32'h0000_1000);
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!m_tvalid && n < 200);
        check("latency", 256'(n), 256'(128));
        @(negedge clk);
        check("valid_one_cycle", 256'(m_tvalid), 256'(0));
        check("ready_after_out", 256'(s_tready), 256'(1));
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) send(32'h0);
        drain();

        // backpressure with changing input data during the stall
        m_tready = 1'b0;
        send(32'h1234_abcd);
        wait_valid("bp_valid");
        snap = m_tdata;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 s_tvalid = 1'b1;
            s_tdata = $urandom;
            @(negedge clk);
            check("bp_hold", m_tdata, snap);
            check("bp_ready", 256'(s_tready), 256'(0));
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        send(32'hface_0042);
        drain();

        // reset during a stalled output
        m_tready = 1'b0;
        send(32'h0003_0005);
        wait_valid("stall_valid");
        #2 nrst = 1'b0;
        #1 check("rst_out_valid", 256'(m_tvalid), 256'(0));
        check("rst_out_ready", 256'(s_tready), 256'(0));
        model_clear();
        @(posedge clk);
        #1 nrst = 1'b1;
        m_tready = 1'b1;

        // reset 60 cycles into CALC, then a fresh impulse and random samples
        send(32'h4000_c000);
        repeat (60) @(posedge clk);
        #2 nrst = 1'b0;
        #1 check("rst_calc_ready", 256'(s_tready), 256'(0));
        check("rst_calc_valid", 256'(m_tvalid), 256'(0));
        check("rst_calc_data", m_tdata, 256'(0));
        model_clear();
        @(posedge clk);
        #1 nrst = 1'b1;
        send(32'h0000_1000);
        send(32'h1000_0000);
        for (int i = 0; i < 4; i++) send($urandom);
        drain();

        // free-running DC and saturation instances have long reached steady state
        repeat (2400) @(posedge clk);
        @(negedge clk);
        n = 0;
        while (!dc_m_tvalid && n < 300) begin @(negedge clk); n++; end
        check("dc_valid", 256'(dc_m_tvalid), 256'(1));
        check("dc_word", dc_m_tdata, {DC_CH, DC_CH});
        n = 0;
        while (!sat_m_tvalid && n < 300) begin @(negedge clk); n++; end
        check("sat_valid", 256'(sat_m_tvalid), 256'(1));
        check("sat_word", sat_m_tdata, SAT_W);
        check("sb_drained", 256'(exp_q.size()), 256'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
